// File: rtl/digit_pkg.sv
// Constants and helpers shared by the keypad digit path (encoder and scan decoder).
package digit_pkg;

  localparam int BCD_W     = 4;
  localparam int DEC_W     = 10;
  localparam int DIGIT_MAX = 9;

  typedef enum logic {ST_BLANK, ST_SCAN} scan_state_t;

  function automatic logic is_legal_bcd(input logic [BCD_W-1:0] code);
    return code <= BCD_W'(DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_onehot_dec.sv
// Combinational BCD to one-hot decimal lamp decoder; codes 10..15 light nothing.
module bcd_onehot_dec
  import digit_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  output logic [DEC_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (is_legal_bcd(code)) onehot = DEC_W'(1) << code;
  end

endmodule

// File: rtl/bcd_digit_scan_decoder.sv
// Calculator-style BCD digit buffer, time-multiplexed onto one-hot lamps with a one-hot
// digit select and anti-ghosting blank gaps between scan slots.
module bcd_digit_scan_decoder
  import digit_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int SCAN_DIV   = 1000,
  parameter  int BLANK_CYC  = 2,
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [BCD_W-1:0]      in_code,
  output logic                  in_ready,
  input  logic                  clear,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [DEC_W-1:0]      d,
  output logic                  lit,
  output logic                  err,
  output logic [CNT_W-1:0]      count
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int TMR_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic [BCD_W-1:0]      codes_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid_q;
  logic                  xfer;

  scan_state_t           state, state_nxt;
  logic [TMR_W-1:0]      timer, timer_nxt;
  logic [IDX_W-1:0]      index, index_nxt;

  logic [DEC_W-1:0]      dec_out;
  logic [NUM_DIGITS-1:0] sel_p0;
  logic [DEC_W-1:0]      lamp_p0;

  // clear wins over a coincident transfer, so the handshake is gated here too.
  assign xfer = in_valid & in_ready & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) codes_q[k] <= '0;
      valid_q  <= '0;
      count    <= '0;
      err      <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      in_ready <= ~clear;
      if (clear) begin
        valid_q <= '0;
        count   <= '0;
        err     <= 1'b0;
      end else if (xfer) begin
        if (is_legal_bcd(in_code)) begin
          for (int k = NUM_DIGITS - 1; k > 0; k--) codes_q[k] <= codes_q[k-1];
          codes_q[0] <= in_code;
          valid_q    <= {valid_q[NUM_DIGITS-2:0], 1'b1};
          if (count != CNT_W'(NUM_DIGITS)) count <= count + CNT_W'(1);
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      timer <= '0;
      index <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      index <= index_nxt;
    end
  end

  // Index advances when a slot ends, so the first blank after reset still points at slot 0.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer - TMR_W'(1);
    index_nxt = index;
    case (state)
      ST_BLANK: begin
        if (timer == '0) begin
          state_nxt = ST_SCAN;
          timer_nxt = TMR_W'(SCAN_DIV - 1);
        end
      end
      ST_SCAN: begin
        if (timer == '0) begin
          state_nxt = ST_BLANK;
          timer_nxt = TMR_W'(BLANK_CYC - 1);
          index_nxt = (index == IDX_W'(NUM_DIGITS - 1)) ? '0 : index + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        timer_nxt = '0;
        index_nxt = '0;
      end
    endcase
  end

  bcd_onehot_dec u_dec (
    .code   (codes_q[index]),
    .onehot (dec_out)
  );

  always_comb begin
    sel_p0  = '0;
    lamp_p0 = '0;
    if (state == ST_SCAN) begin
      sel_p0 = NUM_DIGITS'(1) << index;
      if (valid_q[index]) lamp_p0 = dec_out;
    end
  end

  // Output register stage: select and lamps change together, one cycle behind the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel <= '0;
      d       <= '0;
      lit     <= 1'b0;
    end else begin
      dig_sel <= sel_p0;
      d       <= lamp_p0;
      lit     <= |lamp_p0;
    end
  end

endmodule

// File: tb/tb_bcd_digit_scan_decoder.sv
// Bench for bcd_digit_scan_decoder: table vectors, hand corner sequences, random traffic.
module tb_bcd_digit_scan_decoder;

  localparam int N     = 4;
  localparam int SDIV  = 4;
  localparam int BCYC  = 1;
  localparam int SLOT  = SDIV + BCYC;
  localparam int CW    = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [3:0]    in_code;
  logic          in_ready;
  logic          clear;
  logic [N-1:0]  dig_sel;
  logic [9:0]    d;
  logic          lit;
  logic          err;
  logic [CW-1:0] count;

  bcd_digit_scan_decoder #(.NUM_DIGITS(N), .SCAN_DIV(SDIV), .BLANK_CYC(BCYC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (in_ready),
    .clear    (clear),
    .dig_sel  (dig_sel),
    .d        (d),
    .lit      (lit),
    .err      (err),
    .count    (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of digits, newest first; edge count since reset release.
  int   q[$];
  bit   m_err;
  bit   m_ready;
  int   edges;

  typedef struct {
    logic       clr;
    logic       vld;
    logic [3:0] code;
    logic [2:0] cnt;
    logic       err;
    logic       rdy;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_err   = 1'b0;
    m_ready = 1'b0;
    edges   = 0;
  endtask

  task automatic step();
    int         en, p, slot;
    logic [3:0] es;
    logic [9:0] ed;
    bit         xfer;
    en = edges + 1;
    es = '0;
    ed = '0;
    if (en >= 2) begin
      p = en - 2;
      if ((p % SLOT) < SDIV) begin
        slot = (p / SLOT) % N;
        es = 4'(1 << slot);
        if (slot < q.size()) ed = 10'(1 << q[slot]);
      end
    end
    @(posedge clk);
    edges = en;
    xfer = in_valid && m_ready && !clear;
    if (clear) begin
      q.delete();
      m_err = 1'b0;
    end else if (xfer) begin
      if (in_code <= 4'd9) begin
        q.push_front(int'(in_code));
        if (q.size() > N) void'(q.pop_back());
      end else begin
        m_err = 1'b1;
      end
    end
    m_ready = !clear;
    #1;
    check("dig_sel", 32'(dig_sel), 32'(es));
    check("d", 32'(d), 32'(ed));
    check("lit", 32'(lit), 32'(|ed));
    check("in_ready", 32'(in_ready), 32'(m_ready));
    check("count", 32'(count), 32'(q.size()));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    clear    = 1'b0;
    in_code  = 4'd0;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      clear    = tbl[i].clr;
      in_valid = tbl[i].vld;
      in_code  = tbl[i].code;
      step();
      check($sformatf("row%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("row%0d_err", i), 32'(err), 32'(tbl[i].err));
      check($sformatf("row%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
    end
    idle();
  endtask

  task automatic wait_sel(input logic [N-1:0] s, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (dig_sel == s) ok = 1'b1;
      else step();
    end
    if (!ok) check({name, "_timeout"}, 32'(dig_sel), 32'(s));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2;
    logic [N-1:0] prev;

    //            clr  vld  code   cnt  err  rdy
    tbl[0]  = '{1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 4'd1,  3'd1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 4'd2,  3'd2, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 4'd3,  3'd3, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 4'd7,  3'd3, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 4'd5,  3'd4, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 4'd6,  3'd4, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'd7,  3'd4, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 4'd8,  3'd4, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 4'd9,  3'd4, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 4'd0,  3'd4, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'hC,  3'd4, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 4'd4,  3'd4, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 4'd2,  3'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'd3,  3'd0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b1};

    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_dig_sel", 32'(dig_sel), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_clk", 32'(in_ready), 32'd0);

    // Entry of 1,2,3 and per-slot lamps.
    apply_rows(0, 4);
    wait_sel(4'b0001, "slot0_a");
    check("slot0_d", 32'(d), 32'(10'b0000001000));
    check("slot0_lit", 32'(lit), 32'd1);
    wait_sel(4'b0010, "slot1_a");
    check("slot1_d", 32'(d), 32'(10'b0000000100));
    wait_sel(4'b0100, "slot2_a");
    check("slot2_d", 32'(d), 32'(10'b0000000010));
    wait_sel(4'b1000, "slot3_a");
    check("slot3_d", 32'(d), 32'd0);
    check("slot3_lit", 32'(lit), 32'd0);

    // Overflow: oldest digits fall off.
    apply_rows(5, 10);
    wait_sel(4'b0001, "slot0_b");
    check("ovf_slot0", 32'(d), 32'(10'b1000000000));
    wait_sel(4'b1000, "slot3_b");
    check("ovf_slot3", 32'(d), 32'(10'b0001000000));

    // Illegal code then a legal one; then clear racing a valid code.
    apply_rows(11, 12);
    wait_sel(4'b0001, "slot0_c");
    check("after_illegal_slot0", 32'(d), 32'(10'b0000010000));
    check("err_held", 32'(err), 32'd1);
    apply_rows(13, 15);
    for (int i = 0; i < 2 * N * SLOT; i++) begin
      step();
      check("dark_after_clear", 32'(d), 32'd0);
    end

    // Refill, then reset in the middle of a lit slot.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_code  = 4'(i + 6);
      step();
    end
    idle();
    wait_sel(4'b0001, "slot0_d");
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_dig_sel", 32'(dig_sel), 32'd0);
    check("async_rst_d", 32'(d), 32'd0);
    check("async_rst_lit", 32'(lit), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_dig_sel", 32'(dig_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ready_first_clk", 32'(in_ready), 32'd1);

    // Scan period measured between successive starts of slot 0.
    e1 = -1;
    e2 = -1;
    prev = dig_sel;
    for (int i = 0; i < 60 && e2 < 0; i++) begin
      step();
      if (dig_sel == 4'b0001 && prev != 4'b0001) begin
        if (e1 < 0) e1 = edges;
        else e2 = edges;
      end
      prev = dig_sel;
    end
    check("scan_period", 32'(e2 - e1), 32'(N * SLOT));

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      clear    = ($urandom_range(0, 19) == 0);
      in_valid = $urandom_range(0, 1);
      in_code  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
